// File: rtl/dcache_2way_if.sv
// Pipeline-side and memory-side signal bundle for the two-way data cache.
// The cache takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_2way_if;
  logic [3:0]   read;
  logic [2:0]   write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_2way #(
  parameter int INDEX_BITS = 3
) (
  input  logic           clock,
  input  logic           reset,
  dcache_2way_if.slave   bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
`endif
);
  localparam int SETS     = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state, next_state;

  logic [127:0]          data [2][SETS];
  logic [TAG_BITS-1:0]   tags [2][SETS];
  logic [1:0][SETS-1:0]  valid, dirty;
  logic [SETS-1:0]       lru;

  // Miss context is captured on leaving IDLE so a dropped request cannot disturb the transfer.
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic                  miss_way;

  logic                  load_en, store_en, req;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [1:0]            word;
  logic                  hit0, hit1, hit, hit_way, victim;
  logic                  idle_hit, store_hit, fill;
  logic [127:0]          hit_line, merged_line;
  logic [31:0]           hit_word, merged_word, store_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [3:0]            byte_en;

  assign load_en   = bus.read[3];
  assign store_en  = bus.write[2];
  assign req       = load_en ^ store_en;
  assign req_tag   = bus.address[31:4+INDEX_BITS];
  assign req_index = bus.address[3+INDEX_BITS:4];
  assign word      = bus.address[3:2];

  assign hit0    = valid[0][req_index] && (tags[0][req_index] == req_tag);
  assign hit1    = valid[1][req_index] && (tags[1][req_index] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;
  assign victim  = !valid[0][req_index] ? 1'b0 :
                   !valid[1][req_index] ? 1'b1 : lru[req_index];

  assign hit_line = data[hit_way][req_index];
  assign hit_word = hit_line[{word, 5'd0} +: 32];
  assign byte_sel = hit_word[{bus.address[1:0], 3'd0} +: 8];
  assign half_sel = bus.address[1] ? hit_word[31:16] : hit_word[15:0];

  assign idle_hit  = (state == IDLE) && req && hit;
  assign store_hit = idle_hit && store_en;
  assign fill      = (state == FETCH) && !bus.mem_busywait;

  assign bus.busywait = req && ((state != IDLE) || !hit);

  always_comb begin
    bus.readdata = '0;
    unique case (bus.read[2:0])
      3'b000:  bus.readdata = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  bus.readdata = {{16{half_sel[15]}}, half_sel};
      3'b010:  bus.readdata = hit_word;
      3'b100:  bus.readdata = {24'd0, byte_sel};
      3'b101:  bus.readdata = {16'd0, half_sel};
      default: bus.readdata = '0;
    endcase
  end

  // Replicate the store data across lanes, then keep only the enabled bytes.
  always_comb begin
    byte_en    = '0;
    store_data = bus.writedata;
    unique case (bus.write[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << bus.address[1:0];
        store_data = {4{bus.writedata[7:0]}};
      end
      2'b01: begin
        byte_en    = bus.address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{bus.writedata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
    merged_word = hit_word;
    for (int b = 0; b < 4; b++)
      if (byte_en[b]) merged_word[b*8 +: 8] = store_data[b*8 +: 8];
    merged_line = hit_line;
    merged_line[{word, 5'd0} +: 32] = merged_word;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    next_state        = state;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (req && !hit)
          next_state = (valid[victim][req_index] && dirty[victim][req_index]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {tags[miss_way][miss_index], miss_index};
        bus.mem_writedata = data[miss_way][miss_index];
        if (!bus.mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {miss_tag, miss_index};
        if (!bus.mem_busywait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      lru        <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
      miss_way   <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && req && !hit) begin
        miss_tag   <= req_tag;
        miss_index <= req_index;
        miss_way   <= victim;
      end
      if (idle_hit)  lru[req_index] <= ~hit_way;
      if (store_hit) dirty[hit_way][req_index] <= 1'b1;
      if (fill) begin
        valid[miss_way][miss_index] <= 1'b1;
        dirty[miss_way][miss_index] <= 1'b0;
        lru[miss_index]             <= ~miss_way;
      end
    end
  end

  // NOTE: line and tag storage is not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clock) begin
    if (store_hit) data[hit_way][req_index] <= merged_line;
    if (fill) begin
      data[miss_way][miss_index] <= bus.mem_readdata;
      tags[miss_way][miss_index] <= miss_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay;

  // The cycle after a fill is the replay of an already-counted miss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      replay     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      replay <= fill;
      if ((state == IDLE) && req && !replay) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dcache_2way.sv
// Self-checking bench for dcache_2way: directed test-plan steps, then random traffic
// against a byte-level golden memory and an MRU-ordered per-set residency model.
module tb_dcache_2way;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_2way_if ifc ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_2way #(.INDEX_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing memory (what the cache writes back to / fetches from) and golden view (what loads must see).
  logic [127:0] mem_lines  [logic [27:0]];
  logic [127:0] gold_lines [logic [27:0]];

  function automatic logic [127:0] base_line(input logic [27:0] la);
    if (la == 28'h4) return 128'h44444444_33333333_22222222_11111111;
    return {~{4'h0, la}, {4'h3, la} ^ 32'h0F0F_0F0F, {4'h2, la} * 32'd7, {4'h1, la} + 32'h8001_0203};
  endfunction

  function automatic logic [127:0] mline(input logic [27:0] la);
    return mem_lines.exists(la) ? mem_lines[la] : base_line(la);
  endfunction

  function automatic logic [127:0] gline(input logic [27:0] la);
    return gold_lines.exists(la) ? gold_lines[la] : base_line(la);
  endfunction

  function automatic logic [7:0] gbyte(input logic [31:0] a);
    logic [127:0] l;
    l = gline(a[31:4]);
    return l[a[3:0]*8 +: 8];
  endfunction

  function automatic void set_gbyte(input logic [31:0] a, input logic [7:0] v);
    logic [127:0] l;
    l = gline(a[31:4]);
    l[a[3:0]*8 +: 8] = v;
    gold_lines[a[31:4]] = l;
  endfunction

  function automatic logic [31:0] load_exp(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] h, w;
    h = a & ~32'd1;
    w = a & ~32'd3;
    case (f)
      3'b000:  return {{24{gbyte(a)[7]}}, gbyte(a)};
      3'b001:  return {{16{gbyte(h + 1)[7]}}, gbyte(h + 1), gbyte(h)};
      3'b010:  return {gbyte(w + 3), gbyte(w + 2), gbyte(w + 1), gbyte(w)};
      3'b100:  return {24'd0, gbyte(a)};
      3'b101:  return {16'd0, gbyte(h + 1), gbyte(h)};
      default: return 32'd0;
    endcase
  endfunction

  // Residency model: per set, resident line addresses in most-recently-used-first order.
  logic [27:0] res_q [8][$];
  bit          dirty_m [logic [27:0]];
  int unsigned hit_m = 0, miss_m = 0;

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) res_q[s].delete();
    dirty_m.delete();
    gold_lines = mem_lines;
    hit_m  = 0;
    miss_m = 0;
  endfunction

  // Memory responder: random latency per transfer, records writebacks and fetches.
  bit           hold_busy = 1'b0;
  bit           active = 1'b0;
  int           lat_cnt = 0;
  logic [27:0]  req_addr;
  int unsigned  fetch_cnt = 0;
  logic [27:0]  wb_addr_q [$];
  logic [127:0] wb_line_q [$];

  initial begin
    ifc.mem_busywait = 1'b1;
    ifc.mem_readdata = '0;
  end

  always @(negedge clock) begin
    if (reset) begin
      active = 1'b0;
      ifc.mem_busywait = 1'b1;
    end else if (ifc.mem_read || ifc.mem_write) begin
      check("mem_rd_wr_exclusive", {ifc.mem_read, ifc.mem_write} == 2'b11, 1'b0);
      if (!active) begin
        active   = 1'b1;
        lat_cnt  = $urandom_range(0, 2);
        req_addr = ifc.mem_address;
      end
      if (hold_busy || lat_cnt > 0) begin
        ifc.mem_busywait = 1'b1;
        if (!hold_busy) lat_cnt--;
      end else begin
        check("mem_address_stable", ifc.mem_address, req_addr);
        ifc.mem_busywait = 1'b0;
        active = 1'b0;
        if (ifc.mem_write) begin
          mem_lines[ifc.mem_address] = ifc.mem_writedata;
          wb_addr_q.push_back(ifc.mem_address);
          wb_line_q.push_back(ifc.mem_writedata);
        end else begin
          ifc.mem_readdata = mline(ifc.mem_address);
          fetch_cnt++;
        end
      end
    end else begin
      active = 1'b0;
      ifc.mem_busywait = 1'b1;
    end
  end

  // One pipeline request, held until busywait drops; starts and ends just after a posedge.
  task automatic access(input bit is_store, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    logic [27:0] la, victim;
    logic [2:0]  s;
    bit          hit, exp_wb;
    int          pos, n, nb;
    logic [31:0] base;
    la = a[31:4];
    s  = la[2:0];
    hit = 1'b0; pos = 0; exp_wb = 1'b0; victim = '0;
    for (int i = 0; i < res_q[s].size(); i++)
      if (res_q[s][i] == la) begin hit = 1'b1; pos = i; end
    if (!hit && res_q[s].size() == 2) begin
      victim = res_q[s][1];
      exp_wb = dirty_m.exists(victim) && dirty_m[victim];
    end
    wb_addr_q.delete(); wb_line_q.delete(); fetch_cnt = 0;

    ifc.read      = is_store ? 4'b0000 : {1'b1, f};
    ifc.write     = is_store ? {1'b1, f[1:0]} : 3'b000;
    ifc.address   = a;
    ifc.writedata = wd;
    @(negedge clock);
    check("busywait_first_cycle", ifc.busywait, !hit);
    n = 0;
    while (ifc.busywait === 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n == 64) check("miss_timeout", ifc.busywait, 1'b0);
    if (!is_store) check("load_data", ifc.readdata, load_exp(f, a));
    rd = ifc.readdata;
    @(posedge clock); #1;
    ifc.read  = 4'b0000;
    ifc.write = 3'b000;

    check("fetch_count", fetch_cnt, hit ? 0 : 1);
    check("writeback_count", wb_addr_q.size(), exp_wb ? 1 : 0);
    if (exp_wb && wb_addr_q.size() > 0) begin
      check("writeback_address", wb_addr_q[0], victim);
      check("writeback_line", wb_line_q[0], gline(victim));
    end

    if (hit) begin
      res_q[s].delete(pos);
      hit_m++;
    end else begin
      if (res_q[s].size() == 2) begin
        dirty_m.delete(victim);
        void'(res_q[s].pop_back());
      end
      miss_m++;
    end
    res_q[s].push_front(la);
    if (is_store && f[1:0] != 2'b11) begin
      nb   = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      base = a & ~(nb - 1);
      for (int i = 0; i < nb; i++) set_gbyte(base + i, wd[i*8 +: 8]);
      dirty_m[la] = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] rd;
  logic [2:0]  f_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

  initial begin
    ifc.read = '0; ifc.write = '0; ifc.address = '0; ifc.writedata = '0;
    model_reset();

    // Reset state with a request pending: memory side quiet, request reported as a stall.
    ifc.read = 4'b1010; ifc.address = 32'h40;
    repeat (2) @(negedge clock);
    check("reset_mem_read", ifc.mem_read, 1'b0);
    check("reset_mem_write", ifc.mem_write, 1'b0);
    check("reset_mem_address", ifc.mem_address, 28'h0);
    check("reset_mem_writedata", ifc.mem_writedata, 128'h0);
    check("reset_busywait", ifc.busywait, 1'b1);
    ifc.read = 4'b0000;
    @(negedge clock);
    check("idle_busywait", ifc.busywait, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold LW then a hitting repeat.
    access(1'b0, 3'b010, 32'h40, 32'h0, rd);
    check("tp_first_lw", rd, 32'h11111111);
    access(1'b0, 3'b010, 32'h40, 32'h0, rd);
    check("tp_repeat_lw", rd, 32'h11111111);

    // Byte store and extended loads of the merged word.
    access(1'b1, 3'b000, 32'h41, 32'h80, rd);
    access(1'b0, 3'b000, 32'h41, 32'h0, rd);
    check("tp_lb", rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h41, 32'h0, rd);
    check("tp_lbu", rd, 32'h00000080);
    access(1'b0, 3'b101, 32'h40, 32'h0, rd);
    check("tp_lhu", rd, 32'h00008011);

    // Both enables set is an idle cycle.
    ifc.read = 4'b1010; ifc.write = 3'b110; ifc.address = 32'h3000;
    @(negedge clock);
    check("both_enables_busywait", ifc.busywait, 1'b0);
    check("both_enables_mem_read", ifc.mem_read, 1'b0);
    @(posedge clock); #1;
    ifc.read = '0; ifc.write = '0;

    // Same-set conflict: third line evicts the dirty 0x040 line.
    access(1'b0, 3'b010, 32'h840, 32'h0, rd);
    access(1'b0, 3'b010, 32'h1040, 32'h0, rd);
    check("tp_evict_addr", wb_addr_q.size() > 0 ? wb_addr_q[0] : 28'hFFFFFFF, 28'h0000004);

    // LRU: touching A makes B the victim.
    access(1'b0, 3'b010, 32'h050, 32'h0, rd);
    access(1'b0, 3'b010, 32'h850, 32'h0, rd);
    access(1'b0, 3'b010, 32'h050, 32'h0, rd);
    access(1'b0, 3'b010, 32'h1050, 32'h0, rd);
    access(1'b0, 3'b010, 32'h050, 32'h0, rd);

    // Reset during a stalled FETCH aborts it; the address misses again afterwards.
    hold_busy = 1'b1;
    ifc.read = 4'b1010; ifc.address = 32'h2060;
    @(negedge clock);
    check("abort_busywait", ifc.busywait, 1'b1);
    @(negedge clock);
    check("abort_mem_read_before", ifc.mem_read, 1'b1);
    check("abort_mem_address", ifc.mem_address, 28'h206);
    #2 reset = 1'b1;
    #1;
    check("abort_mem_read_after", ifc.mem_read, 1'b0);
    check("abort_mem_address_after", ifc.mem_address, 28'h0);
    ifc.read = 4'b0000;
    @(posedge clock); #1;
    reset = 1'b0;
    hold_busy = 1'b0;
    model_reset();
    access(1'b0, 3'b010, 32'h2060, 32'h0, rd);

    // Random traffic over a few conflicting lines in two sets.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      bit          st;
      logic [2:0]  f;
      a  = 32'h0001_0000 | ($urandom_range(0, 3) << 7) | ($urandom_range(0, 1) << 4) | $urandom_range(0, 15);
      st = $urandom_range(0, 1);
      f  = st ? 3'($urandom_range(0, 2)) : f_tab[$urandom_range(0, 6)];
      access(st, f, a, $urandom, rd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

`ifdef DCACHE_STATS_EN
    reset = 1'b1;
    #3 reset = 1'b0;
    @(posedge clock); #1;
    model_reset();
    access(1'b0, 3'b010, 32'h100, 32'h0, rd);
    access(1'b0, 3'b010, 32'h104, 32'h0, rd);
    access(1'b0, 3'b010, 32'h200, 32'h0, rd);
    access(1'b0, 3'b010, 32'h108, 32'h0, rd);
    access(1'b0, 3'b010, 32'h20C, 32'h0, rd);
    check("stats_hit_count", hit_count, 32'd3);
    check("stats_miss_count", miss_count, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
